// File: rtl/apa102_pkg.sv
// Shared constants for the APA102 text scroller: lowercase 8x8 font, frame framing helpers, FSM states.
// Glyph row 0 is the most significant byte; bit 7 of each row byte is the leftmost column.
package apa102_pkg;

    localparam int START_BITS = 32;
    localparam logic [2:0] LED_HDR = 3'b111;

    localparam logic [0:25][63:0] FONT_ROM = {
        64'h00003c063e663e00, 64'he0607c666666dc00, 64'h00003c6660663c00, 64'h0e063e6666663b00,
        64'h00003c667e603c00, 64'h1c36307830307800, 64'h00003b66663e067c, 64'he0606c766666e600,
        64'h1800381818183c00, 64'h06000e060666663c, 64'he060666c786ce600, 64'h7030303030307800,
        64'h0000ccfed6d6c600, 64'h0000dc6666666600, 64'h00003c6666663c00, 64'h0000dc66667c60f0,
        64'h000076cccc7c0c1e, 64'h0000dc766060f000, 64'h00003e603c067c00, 64'h10307c3030341800,
        64'h0000666666663b00, 64'h00006666663c1800, 64'h0000c6d6d6fe6c00, 64'h0000c66c386cc600,
        64'h00006666663e067c, 64'h00007e4c18327e00
    };

    typedef enum logic [2:0] {S_IDLE, S_START, S_PIXELS, S_END, S_DONE} frame_state_t;

    function automatic int end_bits(input int n_leds);
        return 32 * ((n_leds + 63) / 64);
    endfunction

endpackage

// File: rtl/apa102_bit_tx.sv
// Serialises 32-bit words MSB first onto led_clk/led_data, 2*CLK_DIV clocks per bit.
// word_rdy is high in the last clock of the current word (or when idle); no word then means stop.
module apa102_bit_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word,
    input  logic        word_vld,
    output logic        word_rdy,
    output logic        led_clk,
    output logic        led_data
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] RISE = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);

    logic          active;
    logic [CW-1:0] cyc;
    logic [4:0]    bit_idx;
    logic [31:0]   sh;

    assign word_rdy = !active || (bit_idx == 5'd31 && cyc == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            cyc      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            led_clk  <= 1'b0;
            led_data <= 1'b0;
        end else if (word_vld && word_rdy) begin
            active   <= 1'b1;
            sh       <= {word[30:0], 1'b0};
            led_data <= word[31];
            led_clk  <= 1'b0;
            cyc      <= '0;
            bit_idx  <= '0;
        end else if (active) begin
            if (cyc == LAST) begin
                led_clk <= 1'b0;
                if (bit_idx == 5'd31) begin
                    // No follow-on word: return to idle-low on both pins.
                    active   <= 1'b0;
                    led_data <= 1'b0;
                end else begin
                    led_data <= sh[31];
                    sh       <= sh << 1;
                    bit_idx  <= bit_idx + 5'd1;
                    cyc      <= '0;
                end
            end else begin
                cyc <= cyc + 1'b1;
                if (cyc == RISE)
                    led_clk <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/apa102_text_scroller.sv
// Renders a host-written message onto an 8xCOLS serpentine APA102 matrix, one frame per start.
// Pixels are fetched combinationally at each word handoff; start is ignored while busy.
module apa102_text_scroller #(
    parameter int COLS       = 8,
    parameter int MSG_DEPTH  = 16,
    parameter int CLK_DIV    = 2,
    parameter int SERPENTINE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [7:0]                   wr_char,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         mode,
    input  logic [31:0]                  fg_color,
    input  logic [31:0]                  bg_color,
    input  logic                         start,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         led_clk,
    output logic                         led_data
);
    import apa102_pkg::*;

    localparam int AW        = $clog2(MSG_DEPTH);
    localparam int PW        = $clog2(8 * MSG_DEPTH);
    localparam int VW        = PW + 7;
    localparam int CWID      = $clog2(COLS);
    localparam int END_WORDS = end_bits(8 * COLS) / 32;

    frame_state_t    state, state_nxt;
    logic [7:0]      msg_buf [MSG_DEPTH];
    logic [PW-1:0]   pos;
    logic [PW:0]     pos_inc, range_q;
    logic [AW:0]     len_q;
    logic            mode_q;
    logic [31:0]     fg_q, bg_q;
    logic [2:0]      row;
    logic [CWID-1:0] col, c;
    logic [3:0]      end_cnt;
    logic            tx_vld, tx_rdy;
    logic [31:0]     tx_word, pix_word;
    logic            frame_go, pix_adv, end_adv, frame_fin;
    logic [VW-1:0]   v;
    logic [AW-1:0]   ch_addr;
    logic [2:0]      gcol;
    logic            in_view, lit;
    logic [7:0]      ch;
    logic [4:0]      gidx;

    function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
        return (len > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : len;
    endfunction

    // Number of distinct pos values: L characters in static mode, 8L columns when scrolling.
    function automatic logic [PW:0] pos_range(input logic [AW:0] len, input logic md);
        return md ? {len, 3'b000} : (PW+1)'(len);
    endfunction

    assign busy    = (state != S_IDLE);
    assign range_q = pos_range(len_q, mode_q);
    assign pos_inc = {1'b0, pos} + 1'b1;

    always_comb begin
        c = ((SERPENTINE != 0) && row[0]) ? CWID'(COLS - 1) - col : col;
        v = VW'(pos) + VW'(c);
        // pos < 8L but pos + c may wrap several times when COLS exceeds 8L.
        for (int i = 0; i <= COLS / 8; i++)
            if (v >= VW'(range_q))
                v = v - VW'(range_q);
        if (mode_q) begin
            ch_addr = v[PW-1:3];
            gcol    = v[2:0];
            in_view = 1'b1;
        end else begin
            ch_addr = pos[AW-1:0];
            gcol    = c[2:0];
            in_view = (32'(c) < 32'd8);
        end
        ch       = msg_buf[ch_addr];
        gidx     = 5'(ch - 8'h61);
        lit      = (len_q != '0) && in_view && (ch >= 8'h61) && (ch <= 8'h7a)
                   && FONT_ROM[gidx][~{row, gcol}];
        pix_word = (lit ? fg_q : bg_q) | {LED_HDR, 29'd0};
    end

    always_comb begin
        state_nxt = state;
        tx_vld    = 1'b0;
        tx_word   = '0;
        frame_go  = 1'b0;
        pix_adv   = 1'b0;
        end_adv   = 1'b0;
        frame_fin = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                tx_vld    = 1'b1;
                frame_go  = 1'b1;
                state_nxt = S_START;
            end
            S_START, S_PIXELS: if (tx_rdy) begin
                tx_vld    = 1'b1;
                tx_word   = pix_word;
                pix_adv   = 1'b1;
                state_nxt = (row == 3'd7 && col == CWID'(COLS - 1)) ? S_END : S_PIXELS;
            end
            S_END: if (tx_rdy) begin
                tx_vld  = 1'b1;
                tx_word = '1;
                end_adv = 1'b1;
                if (end_cnt == 4'(END_WORDS - 1))
                    state_nxt = S_DONE;
            end
            S_DONE: if (tx_rdy) begin
                frame_fin = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos        <= '0;
            len_q      <= '0;
            mode_q     <= 1'b0;
            fg_q       <= '0;
            bg_q       <= '0;
            row        <= '0;
            col        <= '0;
            end_cnt    <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < MSG_DEPTH; i++)
                msg_buf[i] <= '0;
        end else begin
            frame_done <= frame_fin;
            if (wr_en)
                msg_buf[wr_addr] <= wr_char;
            if (frame_go) begin
                len_q   <= clamp_len(msg_len);
                mode_q  <= mode;
                fg_q    <= fg_color;
                bg_q    <= bg_color;
                row     <= '0;
                col     <= '0;
                end_cnt <= '0;
                if ({1'b0, pos} >= pos_range(clamp_len(msg_len), mode))
                    pos <= '0;
            end
            if (pix_adv) begin
                if (col == CWID'(COLS - 1)) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (end_adv)
                end_cnt <= end_cnt + 4'd1;
            if (frame_fin)
                pos <= (pos_inc >= range_q) ? '0 : pos_inc[PW-1:0];
        end
    end

    apa102_bit_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .word     (tx_word),
        .word_vld (tx_vld),
        .word_rdy (tx_rdy),
        .led_clk  (led_clk),
        .led_data (led_data)
    );

endmodule

// File: tb/tb_apa102_text_scroller.sv
// Directed bench for apa102_text_scroller: 8x8 serpentine matrix, CLK_DIV=1, frames captured off led_clk.
module tb_apa102_text_scroller;

    localparam int W          = 66;    // start word + 64 LED words + 1 end word
    localparam int TB_BITS    = 2112;
    localparam int FRAME_CLKS = 4224;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_char = '0;
    logic [4:0]  msg_len = '0;
    logic        mode = 1'b0;
    logic [31:0] fg_color = '0;
    logic [31:0] bg_color = '0;
    logic        start = 1'b0;
    logic        busy, frame_done, led_clk, led_data;

    int          vectors = 0;
    int          miscompares = 0;
    int          bit_cnt = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          bad;
    logic [31:0] shreg = '0;
    logic [31:0] words [W];
    logic [31:0] ref_b [W];

    always #5 clk = ~clk;

    apa102_text_scroller #(.COLS(8), .MSG_DEPTH(16), .CLK_DIV(1), .SERPENTINE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .msg_len    (msg_len),
        .mode       (mode),
        .fg_color   (fg_color),
        .bg_color   (bg_color),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .led_clk    (led_clk),
        .led_data   (led_data)
    );

    always @(posedge led_clk) begin
        shreg = {shreg[30:0], led_data};
        bit_cnt++;
        if (bit_cnt % 32 == 0 && bit_cnt <= 32 * W)
            words[bit_cnt / 32 - 1] = shreg;
    end

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_char(input logic [3:0] addr, input logic [7:0] chr);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr; wr_char = chr;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mid_start < 0: no extra start; otherwise re-pulse start that many clocks into the frame.
    task automatic run_frame(input int mid_start);
        logic seen;
        seen = 1'b0;
        bit_cnt = 0; busy_cnt = 0; done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < FRAME_CLKS + 100; i++) begin
            @(negedge clk);
            start = (i == mid_start);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("frame_done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_led_clk", 32'(led_clk), 32'd0);
        chk("rst_led_data", 32'(led_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_pos", 32'(dut.pos), 32'd0);
        rst = 1'b0;

        // Empty message: framing, timing and all-background LEDs with forced header
        msg_len = 5'd0; mode = 1'b0; fg_color = 32'h000000ff; bg_color = 32'h00123456;
        run_frame(-1);
        chk("busy_clocks", busy_cnt, FRAME_CLKS);
        chk("done_pulses", done_cnt, 1);
        chk("total_bits", bit_cnt, TB_BITS);
        chk("start_word", words[0], 32'h00000000);
        chk("end_word", words[W-1], 32'hffffffff);
        bad = 0;
        for (int k = 0; k < 64; k++) if (words[1+k] !== 32'he0123456) bad++;
        chk("len0_all_bg", bad, 0);
        chk("len0_pos_hold", 32'(dut.pos), 32'd0);

        // Static "ab": 'a' then 'b'
        write_char(4'd0, 8'h61);
        write_char(4'd1, 8'h62);
        msg_len = 5'd2; fg_color = 32'he00000ff; bg_color = 32'he0000000;
        run_frame(-1);
        chk("static_a_led0", words[1+0], 32'he0000000);
        chk("static_a_led2", words[1+2], 32'he0000000);
        chk("static_a_led18", words[1+18], 32'he00000ff);
        chk("static_pos_after_a", 32'(dut.pos), 32'd1);
        run_frame(-1);
        chk("static_b_led0", words[1+0], 32'he00000ff);
        chk("static_b_led14", words[1+14], 32'he00000ff);
        chk("static_b_led15", words[1+15], 32'he0000000);
        chk("static_pos_wrap", 32'(dut.pos), 32'd0);
        for (int k = 0; k < W; k++) ref_b[k] = words[k];

        // Scroll "ab": pos walks 0..15 and wraps
        mode = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("scroll_pos%0d", j), 32'(dut.pos), j);
            run_frame(-1);
            if (j == 4) begin
                chk("scroll4_led4", words[1+4], 32'he00000ff);
                chk("scroll4_led7", words[1+7], 32'he0000000);
            end
            if (j == 8) begin
                bad = 0;
                for (int k = 0; k < W; k++) if (words[k] !== ref_b[k]) bad++;
                chk("scroll8_eq_static_b", bad, 0);
            end
        end
        chk("scroll_pos_wrap", 32'(dut.pos), 32'd0);

        // Serpentine odd row with 'l' row 1 = 0x30
        write_char(4'd0, 8'h6c);
        msg_len = 5'd1; mode = 1'b0;
        run_frame(-1);
        chk("serp_led10", words[1+10], 32'he0000000);
        chk("serp_led11", words[1+11], 32'he0000000);
        chk("serp_led12", words[1+12], 32'he00000ff);
        chk("serp_led13", words[1+13], 32'he00000ff);

        // Non-letter renders background; start while busy is ignored
        write_char(4'd0, 8'h21);
        mode = 1'b1; fg_color = 32'hffffffff; bg_color = 32'h0a0b0c0d;
        run_frame(1000);
        chk("busy_start_clocks", busy_cnt, FRAME_CLKS);
        chk("busy_start_done", done_cnt, 1);
        chk("busy_start_idle", 32'(busy), 32'd0);
        bad = 0;
        for (int k = 0; k < 64; k++) if (words[1+k] !== 32'hea0b0c0d) bad++;
        chk("bang_all_bg", bad, 0);
        chk("bang_pos", 32'(dut.pos), 32'd1);

        // Reset in the middle of the pixel phase
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (800) @(negedge clk);
        for (int i = 0; i < 4 && !led_clk; i++) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_led_clk", 32'(led_clk), 32'd0);
        chk("mid_rst_led_data", 32'(led_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
        chk("mid_rst_pos", 32'(dut.pos), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_no_done", done_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apa102_text_scroller.md
Name: apa102_text_scroller

Overview:
- Parametrised successor to the team's fixed 8x8 "hello" LED-matrix driver.
- Renders a host-written message from a lowercase 8x8 font onto an APA102-style serpentine matrix of 8 rows by COLS columns.
- Message, colours and length are runtime-programmable.
- Supports static per-character display and column-wise left scrolling; one serial frame is emitted per start.
- Sits between a host register/config interface and the two-wire LED strip pins.

Parameters:
COLS, 8, matrix width in columns (8..64); height fixed at 8 rows (font height)
MSG_DEPTH, 16, message buffer depth in characters (power of 2, >=2)
CLK_DIV, 2, system clocks per led_clk half-period (>=1)
SERPENTINE, 1, 1 = odd rows wired right-to-left; 0 = all rows left-to-right

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  message buffer write strobe
wr_addr  in  $clog2(MSG_DEPTH)  write address
wr_char  in  8  ASCII character
msg_len  in  $clog2(MSG_DEPTH)+1  active message length in characters
mode  in  1  0 = static (one character per frame), 1 = scroll
fg_color  in  32  APA102 LED frame for lit pixels
bg_color  in  32  APA102 LED frame for unlit pixels
start  in  1  begin one frame (pulse)
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last end-frame bit
led_clk  out  1  strip clock
led_data  out  1  strip data

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: led_clk=0, led_data=0, busy=0, frame_done=0, pos=0, all buffer entries=8'h00.
- Reset mid-frame abandons the frame immediately; no partial end frame is sent.
- Frame: 32 zero bits, then N=8*COLS LED words of 32 bits each (MSB first), then END_BITS=32*((N+63)/64) one bits. Total bits TB = 32+32N+END_BITS.
- Bit timing: led_clk low for CLK_DIV clocks, then high for CLK_DIV clocks.
  - led_data changes only at the start of the low phase.
  - led_clk is idle low; one bit takes 2*CLK_DIV clocks.
- Handshake:
  - start while !busy: snapshot msg_len, mode, fg_color and bg_color; busy rises on the next clock; the first bit's low phase begins that clock.
  - start while busy: ignored.
- Completion: busy falls on the same edge frame_done pulses, exactly 2*CLK_DIV*TB clocks after busy rose.
- Colour words: bits [31:29] are forced to 3'b111 regardless of input.
- Pixel mapping for LED k:
  - r=k/COLS, p=k%COLS.
  - c = COLS-1-p if SERPENTINE and r is odd, else c = p.
- Glyph addressing: glyph row byte r, bit 7 = leftmost column. Characters outside 'a'..'z' render as all-background.
- Static mode:
  - Virtual column v = 8*pos + c for c<8; c>=8 is background.
  - After frame_done, pos = (pos+1) mod L.
- Scroll mode:
  - v = (pos + c) mod (8L); character v/8, glyph column v%8.
  - After frame_done, pos = (pos+1) mod 8L.
- L = min(msg_len snapshot, MSG_DEPTH).
  - L=0: every pixel is background; pos holds 0.
  - pos is reset to 0 if it is >= the new range at start.
- Buffer writes are accepted at any time, including while busy, and are visible to any pixel fetched after the write edge.
- Arithmetic: pos width is $clog2(8*MSG_DEPTH); all mod operations use compare-and-subtract, no dividers except constant power-of-2 shifts (COLS division via row/column counters, not a divider).

Decomposition:
- Shared package apa102_pkg:
  - 26x64-bit lowercase font ROM constant.
  - START_BITS=32.
  - LED frame header 3'b111.
  - END_BITS function.
- Sub-module apa102_bit_tx:
  - Loads a 32-bit word plus valid.
  - Owns the CLK_DIV divider, led_clk and led_data.
  - Raises ready one clock before it needs the next word.
- The top module holds the frame FSM (IDLE, START, PIXELS, END, DONE), row/column counters, buffer and pos.

Test Plan:
- COLS=8, CLK_DIV=1, rst then start -> busy high for exactly 4224 clocks (TB=2112); first 32 bits 0; last 32 bits 1; frame_done single pulse.
- Write "ab", msg_len=2, mode=0, fg=E0_0000FF, bg=E0_000000, two starts -> frame 1 LED k=2 (row 0, col 2 of 'a' = 0x00) is bg, k=18 is fg; frame 2 shows 'b' (LED 0 = fg, since 0xe0 bit 7 set).
- SERPENTINE=1, 'l' glyph row 1 = 0x30 -> LEDs 10 and 11 (reversed odd row: c=5,4) bg, LEDs 12 and 13 (c=3,2) fg.
- Mode=1, msg "ab", 17 consecutive frames -> pos sequence 0..15 then wraps to 0; frame with pos=8 is identical to static 'b'.
- start asserted while busy and rst asserted mid-PIXELS -> start ignored (single frame length); after rst, outputs are 0 within the same cycle and pos=0.
- msg_len=0, and char '!' in buffer with msg_len=1 -> every LED word equals bg_color with top 3 bits forced to 1.
